x_top_rv32i_rf_ctrl: RTL and testbench
======================================

Name: x_top_rv32i_rf_ctrl

Overview:
- Initiator side of the single-port BRAM register-file interface.
- Accepts core requests to read two source registers (rs1, rs2) and/or write one destination register (rd).
- Serialises the requests onto one wnr/addr/data port that drives the lo/hi 16-bit BRAM halves in parallel. The BRAM has 1-cycle read latency.
- Hardwires x0 to zero; sits between the rv32i decode/writeback stages and the register-file BRAM.

Parameters:
- DATA_W, 32, register width; the BRAM port is split into two DATA_W/2 halves externally.
- ADDR_W, 5, register index width (32 registers).

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  asynchronous active-low reset
- o_ready  out  1  high only in IDLE; requests are sampled only when o_ready=1
- i_rd_req  in  1  read request for rs1/rs2
- i_rs1  in  ADDR_W  source register 1 index
- i_rs2  in  ADDR_W  source register 2 index
- i_wr_req  in  1  write request for rd
- i_rd  in  ADDR_W  destination register index
- i_rd_data  in  DATA_W  write data
- o_rs1_data  out  DATA_W  rs1 value, held until the next read completes
- o_rs2_data  out  DATA_W  rs2 value, held until the next read completes
- o_rd_valid  out  1  one-cycle pulse: o_rs1_data/o_rs2_data updated
- o_wr_done  out  1  one-cycle pulse: write committed
- o_bram_wnr  out  1  1=write, 0=read, to the BRAM
- o_bram_addr  out  ADDR_W  BRAM address
- o_bram_wdata  out  DATA_W  BRAM write data ({hi,lo})
- i_bram_rdata  in  DATA_W  BRAM read data, valid the cycle after a read is addressed

Behaviour:
- Reset: all outputs 0 except o_ready=1. State=IDLE, pending-read flag cleared, latched indices/data 0.
- Reset mid-operation aborts the sequence. No write is issued while reset is asserted (o_bram_wnr=0).
- BRAM port signals are combinational from state and latched fields. In IDLE: wnr=0, addr=0, wdata=0.
- States: IDLE, WR, RS1, RS2, CAP.
- IDLE:
  - i_wr_req=1: latch rd/data, go WR.
  - i_rd_req=1 at the same time: also latch rs1/rs2 and set pending.
  - i_rd_req=1 alone: latch rs1/rs2, go RS1.
  - Write has priority, so a same-cycle read of rd returns the new value.
- WR: wnr=1, addr=rd, wdata=data.
  - If rd==0, wnr is forced to 0 (dummy read); timing is unchanged.
  - Next state: RS1 if pending (clear pending), else IDLE.
  - o_wr_done pulses in the cycle after WR.
- RS1: wnr=0, addr=rs1. Next state RS2.
- RS2: wnr=0, addr=rs2. Capture i_bram_rdata into rs1 reg (0 if rs1==0). Next state CAP.
- CAP: capture i_bram_rdata into rs2 reg (0 if rs2==0). Next state IDLE. o_rd_valid pulses the cycle after CAP.
- Latency:
  - Read-only accepted at cycle T: RS1 T+1, RS2 T+2, CAP T+3, o_rd_valid T+4.
  - Write-only: o_wr_done T+2.
  - Combined request: o_wr_done T+2, o_rd_valid T+5.
- i_bram_rdata is never sampled outside RS2/CAP; its value is X/don't-care elsewhere.
- Requests presented while o_ready=0 are ignored and not queued. The requester holds them until accepted.
- o_rs*_data hold their value across writes; they change only at RS2/CAP capture.

Optional Feature:
- Macro X_TOP_RV32I_RF_CTRL_DUPSKIP_EN.
- Defined: if the latched rs1==rs2, RS2 is skipped (RS1 -> CAP).
  - In CAP, both rs1 and rs2 regs capture i_bram_rdata, with x0 zero-forcing applied.
  - Read latency drops by one cycle (o_rd_valid at T+3).
- Undefined: rs1==rs2 takes the full RS1/RS2/CAP sequence with two BRAM reads.

Test Plan:
- Reset, then write x5=0xDEADBEEF, then read rs1=5, rs2=0 -> wnr=1 addr=5 in WR; o_wr_done at T+2; o_rs1_data=0xDEADBEEF, o_rs2_data=0, o_rd_valid at T+4.
- Write x0=0x12345678, then read rs1=0, rs2=0 -> o_bram_wnr never 1; both outputs 0.
- Same-cycle write x7=0xA5A5A5A5 and read rs1=7, rs2=3 (x3 preloaded 0x00000033) -> o_wr_done T+2; o_rd_valid T+5 with 0xA5A5A5A5/0x00000033.
- Assert i_rd_req while busy (o_ready=0) -> ignored; no extra o_rd_valid pulse; o_ready returns 1 after CAP.
- Deassert i_nrst during RS2 -> next cycle state IDLE, all outputs 0, o_ready=1, no o_rd_valid pulse.
- rs1=rs2=9 (x9=0x00000099) -> without macro o_rd_valid at T+4; with X_TOP_RV32I_RF_CTRL_DUPSKIP_EN at T+3; both outputs 0x00000099.

Source files
------------

// File: rtl/x_top_rv32i_rf_ctrl.sv
// Register-file controller: serialises rs1/rs2 reads and rd writes onto a single-port BRAM.
// Optional macro X_TOP_RV32I_RF_CTRL_DUPSKIP_EN: when rs1==rs2 a single BRAM read serves both.
module x_top_rv32i_rf_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  output logic              o_ready,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rd_valid,
  output logic              o_wr_done,
  output logic              o_bram_wnr,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RS1,
    S_RS2,
    S_CAP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_pend;
  logic [ADDR_W-1:0]  r_rs1;
  logic [ADDR_W-1:0]  r_rs2;
  logic [ADDR_W-1:0]  r_rd;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rs1_data;
  logic [DATA_W-1:0]  r_rs2_data;
  logic               r_rd_valid;
  logic               r_wr_done;
  logic               w_dup;

`ifdef X_TOP_RV32I_RF_CTRL_DUPSKIP_EN
  assign w_dup = (r_rs1 == r_rs2);
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_wr_req) begin
          w_next = S_WR;
        end else if (i_rd_req) begin
          w_next = S_RS1;
        end
      end
      S_WR:    w_next = r_pend ? S_RS1 : S_IDLE;
      S_RS1:   w_next = w_dup ? S_CAP : S_RS2;
      S_RS2:   w_next = S_CAP;
      S_CAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A write to x0 is turned into a harmless read so the BRAM copy of x0 is never touched.
  always_comb begin
    o_bram_wnr   = 1'b0;
    o_bram_addr  = '0;
    o_bram_wdata = '0;
    case (r_state)
      S_WR: begin
        o_bram_wnr   = (r_rd != '0);
        o_bram_addr  = r_rd;
        o_bram_wdata = r_wdata;
      end
      S_RS1:   o_bram_addr = r_rs1;
      S_RS2:   o_bram_addr = r_rs2;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_pend     <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_CAP);
      r_wr_done  <= (r_state == S_WR);
      case (r_state)
        S_IDLE: begin
          if (i_wr_req) begin
            r_rd    <= i_rd;
            r_wdata <= i_rd_data;
            r_pend  <= i_rd_req;
          end
          if (i_wr_req || i_rd_req) begin
            r_rs1 <= i_rs1;
            r_rs2 <= i_rs2;
          end
        end
        S_WR: r_pend <= 1'b0;
        S_RS2: r_rs1_data <= (r_rs1 == '0) ? '0 : i_bram_rdata;
        S_CAP: begin
          r_rs2_data <= (r_rs2 == '0) ? '0 : i_bram_rdata;
          if (w_dup) begin
            r_rs1_data <= (r_rs1 == '0) ? '0 : i_bram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (r_state == S_IDLE);
  assign o_rs1_data = r_rs1_data;
  assign o_rs2_data = r_rs2_data;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_done  = r_wr_done;

endmodule

// File: tb/tb_x_top_rv32i_rf_ctrl.sv
// Directed self-checking bench for x_top_rv32i_rf_ctrl with a 1-cycle-latency BRAM model.
// Latency expectation for duplicate reads follows X_TOP_RV32I_RF_CTRL_DUPSKIP_EN.
module tb_x_top_rv32i_rf_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

`ifdef X_TOP_RV32I_RF_CTRL_DUPSKIP_EN
  localparam int DUP_LAT = 3;
`else
  localparam int DUP_LAT = 4;
`endif

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              o_ready;
  logic              rdReq = 1'b0;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic              wrReq = 1'b0;
  logic [ADDR_W-1:0] rdIdx = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] o_rs1_data;
  logic [DATA_W-1:0] o_rs2_data;
  logic              o_rd_valid;
  logic              o_wr_done;
  logic              o_bram_wnr;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] o_bram_wdata;
  logic [DATA_W-1:0] bramRdata;

  logic [DATA_W-1:0] mem [32];

  int   checks = 0;
  int   errors = 0;
  int   wrDoneAt;
  int   rdValidAt;
  int   rdValidCnt;
  logic wnrSeen;
  logic [ADDR_W-1:0] wnrAddr;
  logic readyLowSeen;

  always #5 clk = ~clk;

  x_top_rv32i_rf_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .o_ready      (o_ready),
    .i_rd_req     (rdReq),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .i_wr_req     (wrReq),
    .i_rd         (rdIdx),
    .i_rd_data    (wdata),
    .o_rs1_data   (o_rs1_data),
    .o_rs2_data   (o_rs2_data),
    .o_rd_valid   (o_rd_valid),
    .o_wr_done    (o_wr_done),
    .o_bram_wnr   (o_bram_wnr),
    .o_bram_addr  (o_bram_addr),
    .o_bram_wdata (o_bram_wdata),
    .i_bram_rdata (bramRdata)
  );

  // Single-port BRAM, read-first, one cycle of read latency.
  always @(posedge clk) begin
    if (o_bram_wnr) mem[o_bram_addr] <= o_bram_wdata;
    bramRdata <= mem[o_bram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one request for a single cycle, then watches eight cycles and records
  // when the done/valid pulses appear relative to the acceptance cycle T.
  // With poke set, a stray read request is raised while the controller is busy.
  task automatic applyStimulus(input logic wr, input logic [4:0] rd, input logic [31:0] d,
                               input logic rr, input logic [4:0] a, input logic [4:0] b,
                               input logic poke);
    @(posedge clk); #1;
    checkOutput("ready_before_req", {31'd0, o_ready}, 32'd1);
    wrReq = wr; rdIdx = rd; wdata = d;
    rdReq = rr; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    wrReq = 1'b0; rdReq = 1'b0;
    wrDoneAt = 0; rdValidAt = 0; rdValidCnt = 0;
    wnrSeen = 1'b0; wnrAddr = '0; readyLowSeen = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (o_wr_done && wrDoneAt == 0) wrDoneAt = n;
      if (o_rd_valid) begin
        rdValidCnt++;
        if (rdValidAt == 0) rdValidAt = n;
      end
      if (o_bram_wnr) begin
        wnrSeen = 1'b1;
        wnrAddr = o_bram_addr;
      end
      if (!o_ready) readyLowSeen = 1'b1;
      if (poke) begin
        rdReq = (n <= 3);
        rs1 = 5'd1; rs2 = 5'd2;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 32'hFFFF_FFFF;

    // Reset values
    #12;
    checkOutput("rst_ready",   {31'd0, o_ready},    32'd1);
    checkOutput("rst_rs1",     o_rs1_data,          32'd0);
    checkOutput("rst_rs2",     o_rs2_data,          32'd0);
    checkOutput("rst_rdvalid", {31'd0, o_rd_valid}, 32'd0);
    checkOutput("rst_wrdone",  {31'd0, o_wr_done},  32'd0);
    checkOutput("rst_wnr",     {31'd0, o_bram_wnr}, 32'd0);
    checkOutput("rst_addr",    {27'd0, o_bram_addr}, 32'd0);
    @(negedge clk); nrst = 1'b1;

    // Write x5 then read it back alongside x0
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("w5_wnr_seen", {31'd0, wnrSeen}, 32'd1);
    checkOutput("w5_wnr_addr", {27'd0, wnrAddr}, 32'd5);
    checkOutput("w5_done_lat", wrDoneAt, 32'd2);
    checkOutput("w5_no_valid", rdValidCnt, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 1'b0);
    checkOutput("r50_valid_lat", rdValidAt, 32'd4);
    checkOutput("r50_rs1", o_rs1_data, 32'hDEAD_BEEF);
    checkOutput("r50_rs2", o_rs2_data, 32'd0);

    // x0 writes never reach the BRAM and x0 always reads as zero
    applyStimulus(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("w0_no_wnr", {31'd0, wnrSeen}, 32'd0);
    checkOutput("w0_done_lat", wrDoneAt, 32'd2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0);
    checkOutput("r00_no_wnr", {31'd0, wnrSeen}, 32'd0);
    checkOutput("r00_rs1", o_rs1_data, 32'd0);
    checkOutput("r00_rs2", o_rs2_data, 32'd0);
    checkOutput("mem0_untouched", mem[0], 32'hFFFF_FFFF);

    // Combined write x7 + read x7/x3 returns the freshly written value
    applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("w3_done_lat", wrDoneAt, 32'd2);
    applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd3, 1'b0);
    checkOutput("comb_done_lat", wrDoneAt, 32'd2);
    checkOutput("comb_valid_lat", rdValidAt, 32'd5);
    checkOutput("comb_valid_cnt", rdValidCnt, 32'd1);
    checkOutput("comb_rs1", o_rs1_data, 32'hA5A5_A5A5);
    checkOutput("comb_rs2", o_rs2_data, 32'h0000_0033);

    // Requests raised while busy are dropped
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7, 1'b1);
    checkOutput("busy_ready_low", {31'd0, readyLowSeen}, 32'd1);
    checkOutput("busy_valid_cnt", rdValidCnt, 32'd1);
    checkOutput("busy_valid_lat", rdValidAt, 32'd4);
    checkOutput("busy_ready_end", {31'd0, o_ready}, 32'd1);
    checkOutput("busy_rs1", o_rs1_data, 32'hDEAD_BEEF);
    checkOutput("busy_rs2", o_rs2_data, 32'hA5A5_A5A5);

    // Read outputs hold across a write; then duplicate-index read
    applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd0, 1'b0);
    checkOutput("hold_rs1", o_rs1_data, 32'hDEAD_BEEF);
    checkOutput("hold_rs2", o_rs2_data, 32'hA5A5_A5A5);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 1'b0);
    checkOutput("dup_valid_lat", rdValidAt, DUP_LAT);
    checkOutput("dup_rs1", o_rs1_data, 32'h0000_0099);
    checkOutput("dup_rs2", o_rs2_data, 32'h0000_0099);

    // Reset asserted during RS2 aborts the read
    @(posedge clk); #1;
    rdReq = 1'b1; rs1 = 5'd7; rs2 = 5'd3;
    @(posedge clk); #1;
    rdReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_rs2_addr", {27'd0, o_bram_addr}, 32'd3);
    nrst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready",   {31'd0, o_ready},     32'd1);
    checkOutput("abort_rs1",     o_rs1_data,           32'd0);
    checkOutput("abort_rs2",     o_rs2_data,           32'd0);
    checkOutput("abort_rdvalid", {31'd0, o_rd_valid},  32'd0);
    checkOutput("abort_wnr",     {31'd0, o_bram_wnr},  32'd0);
    checkOutput("abort_addr",    {27'd0, o_bram_addr}, 32'd0);
    nrst = 1'b1;
    rdValidCnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (o_rd_valid) rdValidCnt++;
    end
    checkOutput("abort_no_valid", rdValidCnt, 32'd0);
    checkOutput("abort_ready_after", {31'd0, o_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
